// File: rtl/change_dispenser_pkg.sv
// Shared types and defaults for the coin-return dispenser.
// States, default timing constants and the coin unit live here.
package change_dispenser_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EJECT,
    S_WAIT_SENSE,
    S_SETTLE,
    S_DONE,
    S_ERROR
  } dispense_state_t;

  localparam int DEF_MAX_CHANGE    = 3;
  localparam int DEF_AMT_W         = 3;
  localparam int DEF_PULSE_CYCLES  = 4;
  localparam int DEF_SETTLE_CYCLES = 2;
  localparam int DEF_TIMEOUT       = 16;
  localparam int COIN_UNIT         = 5;

  function automatic int tmr_width(int a, int b, int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/change_dispenser_cycle_timer.sv
// Loadable down-counter; zero_o flags the last cycle of a timed state.
// Loading N-1 on state entry makes the state last N cycles.
module cycle_timer #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/change_dispenser.sv
// Coin-return responder: pulses the hopper solenoid per coin,
// confirms each on the exit sensor, reports done or jam.
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int MAX_CHANGE    = DEF_MAX_CHANGE,
  parameter int AMT_W         = DEF_AMT_W,
  parameter int PULSE_CYCLES  = DEF_PULSE_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int TIMEOUT       = DEF_TIMEOUT
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_i,
  input  logic [AMT_W-1:0] amount_i,
  input  logic             coin_sense_i,
  output logic             eject_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [AMT_W-1:0] paid_o
);

  localparam int TMR_W =
    tmr_width(PULSE_CYCLES, SETTLE_CYCLES, TIMEOUT);

  dispense_state_t state_q, state_d;
  logic [AMT_W-1:0] rem_q, paid_q;
  logic             seen_q, err_q;
  logic             eject_q, busy_q, done_q;
  logic             tmr_zero, tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             accept, coin_ok;

  assign accept  = (state_q == S_IDLE) && req_i;
  assign coin_ok = (state_d == S_SETTLE) &&
                   (state_q != S_SETTLE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_i) begin
          if (amount_i == '0)
            state_d = S_DONE;
          else if (amount_i > AMT_W'(MAX_CHANGE))
            state_d = S_ERROR;
          else
            state_d = S_EJECT;
        end
      end
      S_EJECT: begin
        if (tmr_zero)
          state_d = (seen_q || coin_sense_i) ?
                    S_SETTLE : S_WAIT_SENSE;
      end
      S_WAIT_SENSE: begin
        if (coin_sense_i)
          state_d = S_SETTLE;
        else if (tmr_zero)
          state_d = S_ERROR;
      end
      S_SETTLE: begin
        if (tmr_zero)
          state_d = (rem_q != '0) ? S_EJECT : S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERROR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Every timed state is reloaded on entry; no state re-enters itself.
  assign tmr_load = (state_d != state_q);

  always_comb begin
    tmr_val = '0;
    unique case (state_d)
      S_EJECT:      tmr_val = TMR_W'(PULSE_CYCLES - 1);
      S_WAIT_SENSE: tmr_val = TMR_W'(TIMEOUT - 1);
      S_SETTLE:     tmr_val = TMR_W'(SETTLE_CYCLES - 1);
      default:      tmr_val = '0;
    endcase
  end

  cycle_timer #(.W(TMR_W)) u_timer (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      paid_q  <= '0;
      seen_q  <= 1'b0;
      err_q   <= 1'b0;
      eject_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      eject_q <= (state_d == S_EJECT);
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE) ||
                 (state_d == S_ERROR);
      if (accept) begin
        err_q  <= 1'b0;
        paid_q <= '0;
        rem_q  <= amount_i;
        seen_q <= 1'b0;
      end
      if (state_d == S_ERROR)
        err_q <= 1'b1;
      if (state_q == S_EJECT && coin_sense_i)
        seen_q <= 1'b1;
      if (coin_ok) begin
        paid_q <= paid_q + 1'b1;
        rem_q  <= rem_q - 1'b1;
        seen_q <= 1'b0;
      end
    end
  end

  assign eject_o = eject_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign err_o   = err_q;
  assign paid_o  = paid_q;

endmodule
